accum_key_ctrl: RTL and testbench
=================================

// Module: accum_key_ctrl
// PURPOSE
//  Sequences the board-level switch accumulator datapath. Debounces the accumulate and
//  accumulate-reset keys and adds SW into an accumulator register that drives LEDG.
//  Arbitrates that register between key-driven operations and CPU (Nios PIO bridge) writes.
//  Sits in top-level FPGA fabric beside lab7_soc; output feeds LEDG and a readback PIO.
// PARAMETERS
//  DATA_W        8       accumulator / switch / cpu data width
//  DEBOUNCE_CYC  500000  consecutive stable cycles before a key level is accepted (10 ms @ 50 MHz)
//  SYNC_STAGES   2       synchronizer flops on each raw key input (>=2)
// PORTS
//  CLOCK_50       in   1       system clock, 50 MHz
//  reset_reset_n  in   1       async active-low reset
//  accum_n        in   1       raw accumulate key (KEY[3]), active-low, asynchronous
//  accum_reset_n  in   1       raw clear key (KEY[2]), active-low, asynchronous
//  sw             in   DATA_W  switch value, sampled in ADD state
//  cpu_wr_valid   in   1       CPU write request
//  cpu_wr_data    in   DATA_W  CPU write data
//  cpu_wr_ready   out  1       CPU write accepted when valid&&ready
//  accum_out      out  DATA_W  accumulator value (to LEDG)
//  overflow       out  1       sticky carry-out of any accumulate
//  busy           out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (async, reset_reset_n=0): accum_out=0, overflow=0, busy=0, cpu_wr_ready=0 while held;
//   FSM=IDLE; pending flags=0; debounced levels=1 (released); debounce counters=0; sync flops=1.
//  Sync: each key goes through SYNC_STAGES flops before debounce.
//  Debounce (per key): counter increments while synced level != debounced level, else clears;
//   when counter reaches DEBOUNCE_CYC-1 the debounced level flips and the counter clears.
//   Press event = debounced 1->0, one-cycle pulse; release generates no event.
//  Pending: press event sets pend_acc / pend_clr on the next edge; a flag clears on the edge
//   leaving its op state. A press while its flag is already set merges (no queueing).
//   A press event in the same cycle its flag clears re-sets the flag (set wins).
//  FSM states: IDLE, CLEAR, ADD, CPU_WR (every op state lasts exactly 1 cycle, then IDLE).
//   IDLE priority: pend_clr -> CLEAR; else pend_acc -> ADD; else cpu_wr_valid -> CPU_WR.
//   cpu_wr_ready = (state==IDLE) && !pend_clr && !pend_acc (combinational). On the handshake
//   cpu_wr_data is captured into a holding register.
//  Ops (register update on the edge leaving the op state):
//   CLEAR : accum_out<=0, overflow<=0.
//   ADD   : {c,sum}=accum_out+sw (DATA_W+1 bits); accum_out<=sum (wraps mod 2^DATA_W);
//           overflow<=overflow|c.
//   CPU_WR: accum_out<=held data, overflow<=0.
//  Latency: debounced press pulse at cycle t -> pend set at t+1 -> op state t+1..t+2 ->
//   accum_out valid at t+3 if no higher-priority work. CPU handshake at t -> accum_out at t+2.
//  Simultaneous: both keys pending -> CLEAR then ADD (clear-then-add of current sw).
//   CPU requests wait while any key op is pending (keys never starve).
//  A held or bouncing key yields exactly one event per debounced press.
//  Reset mid-operation aborts the op; no partial register update survives.
// TESTING (sim with DEBOUNCE_CYC=4, SYNC_STAGES=2)
//  1 reset, sw=8'h05, clean accum_n press -> accum_out=05 exactly one ADD, overflow=0;
//    second press -> 0A.
//  2 accum_out=FE, sw=03, press -> accum_out=01, overflow=1; press clear -> 00, overflow=0.
//  3 accum_n glitches low for 3 cycles then high -> no event, accum_out unchanged;
//    low 10 cycles -> exactly one ADD.
//  4 both keys debounce in same cycle, accum_out=40, sw=07 -> CLEAR then ADD, final 07.
//  5 cpu_wr_valid=1, data=AA held while accum press pending -> ready low until ADD done,
//    then handshake, accum_out=AA, overflow=0.
//  6 assert reset_reset_n=0 during ADD -> accum_out=00, busy=0 immediately, no update after release.

Source files
------------

// File: rtl/accum_key_ctrl.sv
// Key-driven switch accumulator with CPU write arbitration.
// Two debounced keys (add, clear) and a PIO write share one register.
module accum_key_ctrl #(
    parameter int DATA_W       = 8,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset_reset_n,
    input  logic              accum_n,
    input  logic              accum_reset_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              cpu_wr_valid,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,
    output logic [DATA_W-1:0] accum_out,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ADD,
        CPU_WR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [1:0]             key_raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [CNT_W-1:0]       cnt_q  [2];
    logic [1:0]             synced;
    logic [1:0]             deb_q;
    logic [1:0]             deb_d1_q;
    logic [1:0]             press;

    logic              pend_acc_q;
    logic              pend_clr_q;
    logic              run_q;
    logic              cpu_hs;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W:0]   sum;

    // Index 0 is the accumulate key, index 1 the clear key.
    assign key_raw = {accum_reset_n, accum_n};

    always_comb begin
        synced = '1;
        press  = '0;
        for (int k = 0; k < 2; k++) begin
            synced[k] = sync_q[k][SYNC_STAGES-1];
            press[k]  = deb_d1_q[k] & ~deb_q[k];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < 2; k++) begin
                sync_q[k] <= '1;
                cnt_q[k]  <= '0;
            end
            deb_q    <= '1;
            deb_d1_q <= '1;
        end else begin
            deb_d1_q <= deb_q;
            for (int k = 0; k < 2; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
                if (synced[k] != deb_q[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        deb_q[k] <= synced[k];
                        cnt_q[k] <= '0;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 1'b1;
                    end
                end else begin
                    cnt_q[k] <= '0;
                end
            end
        end
    end

    // run_q keeps the CPU port closed while reset is held.
    assign cpu_wr_ready = run_q && (state_q == IDLE)
                          && !pend_clr_q && !pend_acc_q;
    assign cpu_hs = cpu_wr_valid && cpu_wr_ready;
    assign sum    = {1'b0, accum_out} + {1'b0, sw};
    assign busy   = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pend_clr_q) begin
                    state_d = CLEAR;
                end else if (pend_acc_q) begin
                    state_d = ADD;
                end else if (cpu_hs) begin
                    state_d = CPU_WR;
                end
            end
            CLEAR:   state_d = IDLE;
            ADD:     state_d = IDLE;
            CPU_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            pend_acc_q <= 1'b0;
            pend_clr_q <= 1'b0;
            run_q      <= 1'b0;
            hold_q     <= '0;
            accum_out  <= '0;
            overflow   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            // A new press in the clearing cycle re-arms the flag.
            pend_acc_q <= press[0] | (pend_acc_q & (state_q != ADD));
            pend_clr_q <= press[1] | (pend_clr_q & (state_q != CLEAR));
            if (cpu_hs) begin
                hold_q <= cpu_wr_data;
            end
            unique case (state_q)
                CLEAR: begin
                    accum_out <= '0;
                    overflow  <= 1'b0;
                end
                ADD: begin
                    accum_out <= sum[DATA_W-1:0];
                    overflow  <= overflow | sum[DATA_W];
                end
                CPU_WR: begin
                    accum_out <= hold_q;
                    overflow  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_key_ctrl.sv
// Scoreboard bench for accum_key_ctrl.
// Every completed op (busy falling) pops one expected {overflow, accum}.
module tb_accum_key_ctrl;

    logic       CLOCK_50;
    logic       reset_reset_n;
    logic       accum_n;
    logic       accum_reset_n;
    logic [7:0] sw;
    logic       cpu_wr_valid;
    logic [7:0] cpu_wr_data;
    logic       cpu_wr_ready;
    logic [7:0] accum_out;
    logic       overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0] sb [$];
    logic [8:0] exp_v;
    logic       prev_busy;
    logic [7:0] m_acc;
    logic       m_ovf;

    accum_key_ctrl #(
        .DATA_W      (8),
        .DEBOUNCE_CYC(4),
        .SYNC_STAGES (2)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_reset_n(reset_reset_n),
        .accum_n      (accum_n),
        .accum_reset_n(accum_reset_n),
        .sw           (sw),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .accum_out    (accum_out),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (!reset_reset_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_op got accum=%h ovf=%b",
                             accum_out, overflow);
                end else begin
                    exp_v = sb.pop_front();
                    if ({overflow, accum_out} !== exp_v) begin
                        failures++;
                        $display("FAIL op_result got ovf=%b accum=%h want ovf=%b accum=%h",
                                 overflow, accum_out, exp_v[8], exp_v[7:0]);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    task automatic push_add();
        logic [8:0] t;
        t = {1'b0, m_acc} + {1'b0, sw};
        m_acc = t[7:0];
        m_ovf = m_ovf | t[8];
        sb.push_back({m_ovf, m_acc});
    endtask

    task automatic push_clr();
        m_acc = 8'h00;
        m_ovf = 1'b0;
        sb.push_back({m_ovf, m_acc});
    endtask

    task automatic push_wr(input logic [7:0] d);
        m_acc = d;
        m_ovf = 1'b0;
        sb.push_back({m_ovf, m_acc});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic press_keys(input logic a, input logic c, input int low);
        if (a) accum_n = 1'b0;
        if (c) accum_reset_n = 1'b0;
        repeat (low) @(negedge CLOCK_50);
        accum_n       = 1'b1;
        accum_reset_n = 1'b1;
        repeat (12) @(negedge CLOCK_50);
    endtask

    task automatic cpu_write(input logic [7:0] d, input string nm);
        int n;
        cpu_wr_data  = d;
        cpu_wr_valid = 1'b1;
        push_wr(d);
        n = 0;
        while (!cpu_wr_ready && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (!cpu_wr_ready) begin
            failures++;
            $display("FAIL %s_ready_timeout got ready=%b want 1", nm, cpu_wr_ready);
        end
        @(negedge CLOCK_50);
        cpu_wr_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if ({overflow, accum_out} !== 9'h000) begin
            failures++;
            $display("FAIL reset_accum got %h want 000", {overflow, accum_out});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (cpu_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got %b want 0", cpu_wr_ready);
        end
        #2 reset_reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (cpu_wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready got %b want 1", cpu_wr_ready);
        end
        m_acc = 8'h00;
        m_ovf = 1'b0;
    endtask

    task automatic test_basic_add();
        sw = 8'h05;
        push_add();
        press_keys(1'b1, 1'b0, 10);
        push_add();
        press_keys(1'b1, 1'b0, 10);
        wait_drain();
        checks++;
        if (sb.size() != 0 || accum_out !== 8'h0A) begin
            failures++;
            $display("FAIL basic_add got accum=%h pending=%0d want 0a", accum_out, sb.size());
        end
    endtask

    task automatic test_overflow_clear();
        cpu_write(8'hFE, "ovf_preload");
        sw = 8'h03;
        push_add();
        press_keys(1'b1, 1'b0, 10);
        wait_drain();
        checks++;
        if ({overflow, accum_out} !== 9'h101) begin
            failures++;
            $display("FAIL overflow_add got %h want 101", {overflow, accum_out});
        end
        push_clr();
        press_keys(1'b0, 1'b1, 10);
        wait_drain();
        checks++;
        if (sb.size() != 0 || {overflow, accum_out} !== 9'h000) begin
            failures++;
            $display("FAIL clear got %h want 000", {overflow, accum_out});
        end
    endtask

    task automatic test_glitch();
        sw = 8'h11;
        press_keys(1'b1, 1'b0, 3);
        repeat (8) @(negedge CLOCK_50);
        checks++;
        if (accum_out !== m_acc || sb.size() != 0) begin
            failures++;
            $display("FAIL glitch got accum=%h want %h", accum_out, m_acc);
        end
        push_add();
        press_keys(1'b1, 1'b0, 10);
        wait_drain();
        repeat (8) @(negedge CLOCK_50);
        checks++;
        if (sb.size() != 0 || accum_out !== 8'h11) begin
            failures++;
            $display("FAIL long_press got accum=%h want 11", accum_out);
        end
    endtask

    task automatic test_both_keys();
        cpu_write(8'h40, "both_preload");
        sw = 8'h07;
        push_clr();
        push_add();
        press_keys(1'b1, 1'b1, 10);
        wait_drain();
        checks++;
        if (sb.size() != 0 || {overflow, accum_out} !== 9'h007) begin
            failures++;
            $display("FAIL both_keys got %h want 007", {overflow, accum_out});
        end
    endtask

    task automatic test_cpu_wait();
        int n;
        sw = 8'h01;
        push_add();
        push_wr(8'hAA);
        accum_n = 1'b0;
        n = 0;
        while (cpu_wr_ready && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (cpu_wr_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pend_blocks_cpu got ready=%b busy=%b want 0 0",
                     cpu_wr_ready, busy);
        end
        cpu_wr_data  = 8'hAA;
        cpu_wr_valid = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b1 || cpu_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_first got busy=%b ready=%b want 1 0", busy, cpu_wr_ready);
        end
        n = 0;
        while (!cpu_wr_ready && n < 20) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (cpu_wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL cpu_wait_timeout got ready=%b want 1", cpu_wr_ready);
        end
        @(negedge CLOCK_50);
        cpu_wr_valid = 1'b0;
        accum_n      = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        wait_drain();
        checks++;
        if (sb.size() != 0 || {overflow, accum_out} !== 9'h0AA) begin
            failures++;
            $display("FAIL cpu_after_add got %h want 0aa", {overflow, accum_out});
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        sw = 8'h10;
        accum_n = 1'b0;
        n = 0;
        while (!busy && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_op_timeout got busy=%b want 1", busy);
        end
        #2;
        reset_reset_n = 1'b0;
        accum_n       = 1'b1;
        #1;
        checks++;
        if ({overflow, accum_out} !== 9'h000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got acc=%h busy=%b want 000 0",
                     {overflow, accum_out}, busy);
        end
        checks++;
        if (cpu_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_ready got %b want 0", cpu_wr_ready);
        end
        m_acc = 8'h00;
        m_ovf = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 reset_reset_n = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if ({overflow, accum_out} !== 9'h000 || busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL post_reset got acc=%h busy=%b want 000 0",
                     {overflow, accum_out}, busy);
        end
    endtask

    initial begin
        reset_reset_n = 1'b0;
        accum_n       = 1'b1;
        accum_reset_n = 1'b1;
        sw            = 8'h00;
        cpu_wr_valid  = 1'b0;
        cpu_wr_data   = 8'h00;
        m_acc         = 8'h00;
        m_ovf         = 1'b0;
        prev_busy     = 1'b0;
        @(negedge CLOCK_50);
        test_reset();
        test_basic_add();
        test_overflow_clear();
        test_glitch();
        test_both_keys();
        test_cpu_wait();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
